// File: rtl/fp16_pkg.sv
// Shared constants and FSM state type for the binary16 unpack/normalize front end.
package fp16_pkg;

  localparam logic signed [6:0] EXP_BIAS    = 7'sd15;
  localparam logic signed [6:0] EXP_ZERO    = -7'sd15;
  localparam logic signed [6:0] EXP_SPECIAL = 7'sd16;
  localparam logic signed [6:0] EXP_SUBNORM = -7'sd14;
  localparam logic [10:0]       QNAN_MANT   = 11'h400;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StEmit = 2'd2
  } unpack_state_e;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero counter over an 11-bit mantissa; an all-zero input reports 11.
module fp16_lzc (
  input  logic [10:0] value,
  output logic [3:0]  count
);

  always_comb begin
    count = 4'd11;
    // Ascending scan so the most significant set bit is the last to win.
    for (int i = 0; i < 11; i++) begin
      if (value[i]) count = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_unpack.sv
// Unpacks an IEEE binary16 operand into sign / hidden-bit mantissa / unbiased exponent and
// class flags. Define FP16_UNPACK_FAST_NORM_EN to normalize subnormals in a single cycle.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  input  logic              ds_ready,
  output logic              n_valid,
  output logic              sign,
  output logic [10:0]       mant,
  output logic signed [6:0] exp,
  output logic              is_nan,
  output logic              is_pinf,
  output logic              is_ninf,
  output logic              is_num
);

  unpack_state_e     state_q, state_d;
  logic              n_valid_d;
  logic              sign_d;
  logic [10:0]       mant_d;
  logic signed [6:0] exp_d;
  logic              is_nan_d, is_pinf_d, is_ninf_d, is_num_d;

  logic              in_sign;
  logic [4:0]        in_exp;
  logic [9:0]        in_frac;

  assign in_sign = in_data[15];
  assign in_exp  = in_data[14:10];
  assign in_frac = in_data[9:0];

  assign in_ready = (state_q == StIdle) && !rst;

`ifdef FP16_UNPACK_FAST_NORM_EN
  logic [3:0] lz_count;

  fp16_lzc u_lzc (
    .value ({1'b0, in_frac}),
    .count (lz_count)
  );
`endif

  always_comb begin
    state_d   = state_q;
    n_valid_d = 1'b0;
    sign_d    = sign;
    mant_d    = mant;
    exp_d     = exp;
    is_nan_d  = is_nan;
    is_pinf_d = is_pinf;
    is_ninf_d = is_ninf;
    is_num_d  = is_num;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          sign_d    = in_sign;
          is_nan_d  = 1'b0;
          is_pinf_d = 1'b0;
          is_ninf_d = 1'b0;
          is_num_d  = 1'b0;
          state_d   = StEmit;
          if (in_exp == 5'd31) begin
            exp_d = EXP_SPECIAL;
            if (in_frac == 10'd0) begin
              mant_d    = 11'd0;
              is_pinf_d = !in_sign;
              is_ninf_d = in_sign;
            end else begin
              mant_d   = QNAN_MANT;
              sign_d   = 1'b1;
              is_nan_d = 1'b1;
            end
          end else if (in_exp == 5'd0 && in_frac == 10'd0) begin
            // Signed zero is a valid sqrt operand, so is_num ignores the sign here.
            mant_d   = 11'd0;
            exp_d    = EXP_ZERO;
            is_num_d = 1'b1;
          end else if (in_exp == 5'd0) begin
            is_num_d = !in_sign;
`ifdef FP16_UNPACK_FAST_NORM_EN
            mant_d = {1'b0, in_frac} << lz_count;
            exp_d  = EXP_SUBNORM - $signed({3'b000, lz_count});
`else
            mant_d  = {1'b0, in_frac};
            exp_d   = EXP_SUBNORM;
            state_d = StNorm;
`endif
          end else begin
            is_num_d = !in_sign;
            mant_d   = {1'b1, in_frac};
            exp_d    = $signed({2'b00, in_exp}) - EXP_BIAS;
          end
        end
      end
      StNorm: begin
        mant_d = {mant[9:0], 1'b0};
        exp_d  = exp - 7'sd1;
        if (mant[9]) state_d = StEmit;
      end
      StEmit: begin
        if (ds_ready) begin
          n_valid_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_valid <= 1'b0;
      sign    <= 1'b0;
      mant    <= 11'd0;
      exp     <= 7'sd0;
      is_nan  <= 1'b0;
      is_pinf <= 1'b0;
      is_ninf <= 1'b0;
      is_num  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_valid <= n_valid_d;
      sign    <= sign_d;
      mant    <= mant_d;
      exp     <= exp_d;
      is_nan  <= is_nan_d;
      is_pinf <= is_pinf_d;
      is_ninf <= is_ninf_d;
      is_num  <= is_num_d;
    end
  end

endmodule

// File: tb/tb_fp16_unpack.sv
// Randomized and directed bench for fp16_unpack against a value-level binary16 reference model.
module tb_fp16_unpack;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              ds_ready;
  logic              n_valid;
  logic              sign;
  logic [10:0]       mant;
  logic signed [6:0] exp;
  logic              is_nan, is_pinf, is_ninf, is_num;

  int checks   = 0;
  int failures = 0;

`ifdef FP16_UNPACK_FAST_NORM_EN
  localparam bit FastMode = 1'b1;
`else
  localparam bit FastMode = 1'b0;
`endif

  always #5 clk = ~clk;

  fp16_unpack dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ds_ready (ds_ready),
    .n_valid  (n_valid),
    .sign     (sign),
    .mant     (mant),
    .exp      (exp),
    .is_nan   (is_nan),
    .is_pinf  (is_pinf),
    .is_ninf  (is_ninf),
    .is_num   (is_num)
  );

  typedef struct {
    int sign, mant, exp, nan, pinf, ninf, num, k;
  } expect_t;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Value-level model: the operand is m * 2^x with m an integer; scale m up to [1024, 2048).
  function automatic expect_t model(input logic [15:0] w);
    expect_t r;
    int s = int'(w[15]);
    int e = int'(w[14:10]);
    int f = int'(w[9:0]);
    int m;
    int x;
    r = '{default: 0};
    if (e == 31) begin
      r.exp = 16;
      if (f == 0) begin
        r.sign = s;
        r.pinf = (s == 0) ? 1 : 0;
        r.ninf = s;
      end else begin
        r.sign = 1;
        r.nan  = 1;
        r.mant = 1024;
      end
    end else if (e == 0 && f == 0) begin
      r.sign = s;
      r.exp  = -15;
      r.num  = 1;
    end else begin
      if (e == 0) begin
        m = f;
        x = -14;
      end else begin
        m = 1024 + f;
        x = e - 15;
      end
      while (m < 1024) begin
        m = m * 2;
        x = x - 1;
        r.k++;
      end
      r.sign = s;
      r.mant = m;
      r.exp  = x;
      r.num  = (s == 0) ? 1 : 0;
    end
    return r;
  endfunction

  task automatic check_fields(input string tag, input expect_t r);
    check({tag, ".sign"}, int'(sign), r.sign);
    check({tag, ".mant"}, int'(mant), r.mant);
    check({tag, ".exp"}, int'(exp), r.exp);
    check({tag, ".nan"}, int'(is_nan), r.nan);
    check({tag, ".pinf"}, int'(is_pinf), r.pinf);
    check({tag, ".ninf"}, int'(is_ninf), r.ninf);
    check({tag, ".num"}, int'(is_num), r.num);
  endtask

  // Accept one word, hold ds_ready low for 'stall' cycles, then wait for the n_valid pulse.
  task automatic send(input string tag, input logic [15:0] w, input int stall);
    expect_t r;
    int base;
    int want_lat;
    int cycles;
    bit seen;
    r    = model(w);
    base = FastMode ? 2 : 2 + r.k;
    want_lat = (stall + 2 > base) ? stall + 2 : base;
    @(negedge clk);
    check({tag, ".in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = w;
    ds_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    cycles   = 1;
    for (int i = 0; i < stall; i++) begin
      check({tag, ".stall_in_ready"}, int'(in_ready), 0);
      check({tag, ".stall_n_valid"}, int'(n_valid), 0);
      if (base == 2) check_fields({tag, ".stall"}, r);
      @(posedge clk);
      #1;
      cycles++;
    end
    ds_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (n_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    check({tag, ".n_valid_seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, ".latency"}, cycles, want_lat);
      check_fields(tag, r);
      @(posedge clk);
      #1;
      check({tag, ".pulse_width"}, int'(n_valid), 0);
      check_fields({tag, ".hold"}, r);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".n_valid"}, int'(n_valid), 0);
    check({tag, ".sign"}, int'(sign), 0);
    check({tag, ".mant"}, int'(mant), 0);
    check({tag, ".exp"}, int'(exp), 0);
    check({tag, ".flags"}, int'({is_nan, is_pinf, is_ninf, is_num}), 0);
  endtask

  // Pulse rst 'delay' cycles after accepting w; no n_valid may follow.
  task automatic reset_mid(input string tag, input logic [15:0] w, input int delay,
                           input logic ds);
    int pulses = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    ds_ready = ds;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (n_valid) pulses++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    ds_ready = 1'b1;
    #1;
    check({tag, ".in_ready_in_rst"}, int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_state(tag);
    check({tag, ".in_ready_after"}, int'(in_ready), 1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (n_valid) pulses++;
    end
    check({tag, ".no_pulse"}, pulses, 0);
  endtask

  initial begin
    logic [15:0] w;
    int cls;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    ds_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", int'(in_ready), 0);
    check_reset_state("rst");
    rst = 1'b0;
    #1;
    check("rst.in_ready_release", int'(in_ready), 1);

    send("one", 16'h3C00, 0);
    send("min_sub", 16'h0001, 0);
    send("neg_zero", 16'h8000, 0);
    send("ninf", 16'hFC00, 0);
    send("qnan", 16'h7E00, 0);
    send("neg_two", 16'hC000, 0);
    send("stall", 16'h4400, 5);
    send("pinf", 16'h7C00, 0);
    send("max_sub", 16'h03FF, 0);
    send("snan_neg", 16'hFC01, 0);
    send("max_norm", 16'h7BFF, 0);
    send("neg_sub", 16'h8200, 2);

    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 4);
      w   = 16'($urandom);
      case (cls)
        0: w[14:10] = 5'd0;
        1: w[14:0] = 15'd0;
        2: w[14:10] = 5'd31;
        default: ;
      endcase
      send($sformatf("rand%0d_%04h", n, w), w, $urandom_range(0, 3));
    end

    reset_mid("rst_norm", 16'h0003, 3, 1'b1);
    reset_mid("rst_emit", 16'h4400, 2, 1'b0);
    send("after_rst", 16'h0003, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
